activation_pipe: RTL and testbench

//  Multi-lane pipelined activation unit. Applies the Alippi piecewise-linear sigmoid, or tanh derived from it,
//  to LANES signed fixed-point inputs per beat. Valid/ready on both sides. Sits between MAC accumulator

---
 rtl/activation_pipe.sv | 185 ++++++++++++++++++
 tb/tb_activation_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : activation_pipe
// Purpose  : Multi-lane, 3-stage pipelined piecewise-linear (Alippi) sigmoid
//            with tanh derived as 2*sigmoid(2x)-1. Valid/ready on both sides,
//            single global enable so a stalled output freezes the whole pipe.
// Options  : define ACT_SAT_CNT_EN to add sat_count/sat_clr, a saturating
//            count of lanes whose mid term collapsed to zero.
// Revision : 1.0 - initial release
// ============================================================================
module activation_pipe #(
  parameter int INT_BIT  = 7,
  parameter int FRAC_BIT = 8,
  parameter int LANES    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_mode,
  input  logic [LANES*(INT_BIT+FRAC_BIT+1)-1:0]  in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*(FRAC_BIT+2)-1:0]          out_data
`ifdef ACT_SAT_CNT_EN
  ,
  output logic [15:0]                            sat_count,
  input  logic                                   sat_clr
`endif
);

  localparam int W_IN  = INT_BIT + FRAC_BIT + 1;
  localparam int W_OUT = FRAC_BIT + 2;
  localparam logic [W_IN-1:0]     C_MAX_POS = {1'b0, {(W_IN-1){1'b1}}};
  localparam logic [W_IN-1:0]     C_MAX_NEG = {1'b1, {(W_IN-2){1'b0}}, 1'b1};
  localparam logic [FRAC_BIT-1:0] C_HALF    = {1'b1, {(FRAC_BIT-1){1'b0}}};
  localparam logic [FRAC_BIT:0]   C_ONE     = {1'b1, {FRAC_BIT{1'b0}}};
  localparam logic [W_OUT-1:0]    C_ONE_OUT = {2'b01, {FRAC_BIT{1'b0}}};

  logic en;
  logic v1_q, v2_q, v3_q;
  logic m1_q, m2_q;

`ifdef ACT_SAT_CNT_EN
  logic [LANES-1:0] zero_vec;
  logic [16:0]      sat_sum;
  logic [15:0]      sat_count_d, sat_count_q;
`endif

  // The pipe only moves when the output slot is free or being drained.
  assign en        = out_ready | ~v3_q;
  assign in_ready  = en;
  assign out_valid = v3_q;

  // Valid bits and per-beat mode travel with the data through S1/S2/S3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      m1_q <= 1'b0;
      m2_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      m1_q <= in_mode;
      m2_q <= m1_q;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [W_IN-1:0]     x, x2, neg;
      logic [W_IN:0]       dbl;
      logic [W_IN-2:0]     a;
      logic                s1_s_d, s1_s_q;
      logic [INT_BIT-1:0]  s1_n_d, s1_n_q;
      logic [FRAC_BIT-1:0] s1_f_d, s1_f_q;
      logic [FRAC_BIT-1:0] sum, s2_mid_d, s2_mid_q;
      logic                s2_s_q;
      logic [FRAC_BIT:0]   sig;
      logic [W_OUT-1:0]    s3_out_d, s3_out_q;

      assign x   = in_data[i*W_IN +: W_IN];
      assign dbl = {x, 1'b0};

      // S1: tanh doubles the input (saturating), then split |x2| into n and f.
      always_comb begin
        x2 = x;
        if (in_mode) begin
          if (dbl[W_IN] != dbl[W_IN-1]) begin
            x2 = x[W_IN-1] ? C_MAX_NEG : C_MAX_POS;
          end else begin
            x2 = dbl[W_IN-1:0];
          end
        end
        neg = ~x2 + W_IN'(1);
        a   = x2[W_IN-2:0];
        if (x2[W_IN-1]) begin
          // Negating the most-negative code overflows; clamp to max magnitude.
          a = neg[W_IN-1] ? C_MAX_POS[W_IN-2:0] : neg[W_IN-2:0];
        end
        s1_s_d = x2[W_IN-1];
        s1_n_d = a[W_IN-2:FRAC_BIT];
        s1_f_d = a[FRAC_BIT-1:0];
      end

      // S2: mid term; large n forced to zero instead of an oversized shift.
      assign sum      = C_HALF + (s1_f_q >> 2);
      assign s2_mid_d = (int'(s1_n_q) >= FRAC_BIT + 1) ? '0 : (sum >> s1_n_q);

      // S3: fold sign back in, then rescale to tanh range when requested.
      always_comb begin
        sig      = s2_s_q ? {1'b0, s2_mid_q} : (C_ONE - {1'b0, s2_mid_q});
        s3_out_d = m2_q ? ({sig, 1'b0} - C_ONE_OUT) : {1'b0, sig};
      end

      // Lane data registers, frozen together with the valid bits on stall.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_s_q   <= 1'b0;
          s1_n_q   <= '0;
          s1_f_q   <= '0;
          s2_s_q   <= 1'b0;
          s2_mid_q <= '0;
          s3_out_q <= '0;
        end else if (en) begin
          s1_s_q   <= s1_s_d;
          s1_n_q   <= s1_n_d;
          s1_f_q   <= s1_f_d;
          s2_s_q   <= s1_s_q;
          s2_mid_q <= s2_mid_d;
          s3_out_q <= s3_out_d;
        end
      end

      assign out_data[i*W_OUT +: W_OUT] = s3_out_q;

`ifdef ACT_SAT_CNT_EN
      logic s3_zero_q;

      // Remember whether this lane's mid term was zero for the counter.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s3_zero_q <= 1'b0;
        end else if (en) begin
          s3_zero_q <= (s2_mid_q == '0);
        end
      end

      assign zero_vec[i] = s3_zero_q;
`endif
    end
  endgenerate

`ifdef ACT_SAT_CNT_EN
  // Add zero-mid lanes on each output transfer; clear wins over increment.
  always_comb begin
    sat_sum = {1'b0, sat_count_q};
    if (v3_q && out_ready) begin
      for (int k = 0; k < LANES; k++) begin
        sat_sum = sat_sum + {16'b0, zero_vec[k]};
      end
    end
    sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    if (sat_clr) begin
      sat_count_d = '0;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_activation_pipe.sv
`default_nettype none
// Bench for activation_pipe: directed vectors, stall, reset, randomized
// traffic checked against an arithmetic reference model and scoreboard.
module tb_activation_pipe;
  localparam int INT_BIT  = 7;
  localparam int FRAC_BIT = 8;
  localparam int LANES    = 4;
  localparam int W_IN     = INT_BIT + FRAC_BIT + 1;
  localparam int W_OUT    = FRAC_BIT + 2;
  localparam int MAXV     = (1 << (W_IN - 1)) - 1;
  localparam int ONE      = 1 << FRAC_BIT;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [LANES*W_IN-1:0]  in_data;
  logic [LANES*W_OUT-1:0] out_data;
`ifdef ACT_SAT_CNT_EN
  logic [15:0] sat_count;
  logic        sat_clr;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sent;
  bit lat_chk;
  bit acc;

  typedef struct {
    logic [LANES*W_OUT-1:0] data;
    int                     c;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  activation_pipe #(.INT_BIT(INT_BIT), .FRAC_BIT(FRAC_BIT), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ACT_SAT_CNT_EN
    ,
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
`endif
  );

  // Reference: value of the activation for one signed input, plain integers.
  function automatic int ref_act(int x, bit tanh_m);
    int x2, a, n, f, mid, sig;
    x2 = x;
    if (tanh_m) begin
      x2 = 2 * x;
      if (x2 > MAXV)  x2 = MAXV;
      if (x2 < -MAXV) x2 = -MAXV;
    end
    a = (x2 < 0) ? -x2 : x2;
    if (a > MAXV) a = MAXV;
    n   = a / ONE;
    f   = a % ONE;
    mid = (n >= FRAC_BIT + 1) ? 0 : ((ONE / 2) + f / 4) / (1 << n);
    sig = (x2 < 0) ? mid : ONE - mid;
    return tanh_m ? (2 * sig - ONE) : sig;
  endfunction

  function automatic logic [LANES*W_OUT-1:0] model_beat(logic [LANES*W_IN-1:0] d, logic m);
    logic [LANES*W_OUT-1:0] r;
    logic signed [W_IN-1:0] x;
    int v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      x = d[l*W_IN +: W_IN];
      v = ref_act(int'(x), m);
      r[l*W_OUT +: W_OUT] = W_OUT'(v);
    end
    return r;
  endfunction

  function automatic logic [W_IN-1:0] rand_lane();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return W_IN'($urandom_range(0, 2047) - 1024);
      3:       return W_IN'($urandom_range(0, 6143) - 3072);
      default: return W_IN'($urandom);
    endcase
  endfunction

  function automatic logic [LANES*W_IN-1:0] rand_beat();
    logic [LANES*W_IN-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*W_IN +: W_IN] = rand_lane();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    if (!rst) begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk("no_dup_output", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("scoreboard_data", out_data, e.data);
          if (lat_chk) chk("scoreboard_latency", cyc - e.c, 3);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sb_q.push_back('{model_beat(in_data, in_mode), cyc});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input string tag, input logic [LANES*W_IN-1:0] d,
                            input logic m, input logic [LANES*W_OUT-1:0] exp);
    int n;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
`ifdef ACT_SAT_CNT_EN
    sat_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 1);
`ifdef ACT_SAT_CNT_EN
    chk("reset_sat_count", sat_count, 0);
`endif
    rst = 1'b0;
    tick();

    // Directed sigmoid / tanh vectors (expected values from the rules by hand).
    send_check("sig_a", {16'h0280, 16'hFF00, 16'h0100, 16'h0000}, 1'b0,
               {10'd216, 10'd64, 10'd192, 10'd128});
    send_check("sig_b", {16'h0040, 16'hEC00, 16'h8000, 16'h1400}, 1'b0,
               {10'd112, 10'd0, 10'd0, 10'd256});
`ifdef ACT_SAT_CNT_EN
    tick();
    chk("sat_after_b", sat_count, 3);
    send_check("sig_b2", {16'h0040, 16'hEC00, 16'h8000, 16'h1400}, 1'b0,
               {10'd112, 10'd0, 10'd0, 10'd256});
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr_override", sat_count, 0);
`endif
    send_check("tanh_a", {16'h7FFF, 16'h0000, 16'hFF80, 16'h0080}, 1'b1,
               {10'd256, 10'd0, 10'h380, 10'd128});
    repeat (2) tick();

    // Ten back-to-back beats with a five-cycle output stall in the middle.
    lat_chk  = 1'b0;
    sent     = 0;
    in_data  = rand_beat();
    in_mode  = 1'($urandom);
    for (int i = 0; i < 30; i++) begin
      in_valid  = (sent < 10);
      out_ready = !(i >= 4 && i < 9);
      tick();
      if (acc) begin
        sent++;
        in_data = rand_beat();
        in_mode = 1'($urandom);
      end
      if (i == 6) chk("stall_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("stall_beats_sent", sent, 10);
    chk("stall_drained", sb_q.size(), 0);

    // Randomized traffic with random back-pressure; source holds unaccepted beats.
    in_valid = 1'b1;
    in_data  = rand_beat();
    in_mode  = 1'($urandom);
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_beat();
        in_mode  = 1'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("random_drained", sb_q.size(), 0);

    // Reset with three beats in flight.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data  = rand_beat();
      in_mode  = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_out_data", out_data, 0);
    sb_q.delete();
    tick();
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_idle", out_valid, 0);
    end
    send_check("post_rst_beat", {16'h0280, 16'hFF00, 16'h0100, 16'h0000}, 1'b0,
               {10'd216, 10'd64, 10'd192, 10'd128});
    repeat (3) tick();
    chk("final_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
